hex_display_bank: RTL and testbench

HEX_DISPLAY_BANK -- requirements
Module: hex_display_bank

---
 rtl/hex_display_bank.sv | 157 +++++++++++++++
 tb/tb_hex_display_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_bank.sv
// rtl/hex_display_bank.sv - Avalon-MM bank of seven-segment hex digits with shadow commit and blink
module hex_display_bank #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    iClk,
    input  logic                    iReset_n,
    input  logic                    iChip_select_n,
    input  logic                    iWrite_n,
    input  logic                    iRead_n,
    input  logic [3:0]              iAddress,
    input  logic [31:0]             iWrite_data,
    output logic [31:0]             oRead_data,
    output logic [NUM_DIGITS*8-1:0] oHex
);
    localparam int               CNT_W    = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_BLANK  = 4'd9;
    localparam logic [3:0] ADDR_BLINK  = 4'd10;
    localparam logic [3:0] ADDR_COMMIT = 4'd11;
    localparam logic [3:0] ADDR_STATUS = 4'd12;

    logic [NUM_DIGITS-1:0][4:0] shadowQ, shadowD;
    logic [NUM_DIGITS-1:0][4:0] activeQ, activeD;
    logic [1:0]                 ctrlQ, ctrlD;
    logic [NUM_DIGITS-1:0]      blankQ, blankD;
    logic [NUM_DIGITS-1:0]      blinkQ, blinkD;
    logic [CNT_W-1:0]           cntQ, cntD;
    logic                       phaseQ, phaseD;
    logic                       pendingQ, pendingD;
    logic [31:0]                readD;
    logic [NUM_DIGITS*8-1:0]    hexD;
    logic                       writeEn, readEn, isDigit;
    logic                       unusedWriteData;

    assign unusedWriteData = ^iWrite_data[31:5];

    function automatic logic [6:0] glyph(input logic [3:0] nibble);
        case (nibble)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h08;
            4'hB:    glyph = 7'h03;
            4'hC:    glyph = 7'h46;
            4'hD:    glyph = 7'h21;
            4'hE:    glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    always_comb begin
        writeEn  = !iChip_select_n && !iWrite_n;
        readEn   = !iChip_select_n && iWrite_n && !iRead_n;
        isDigit  = iAddress < 4'(NUM_DIGITS);

        shadowD  = shadowQ;
        activeD  = activeQ;
        ctrlD    = ctrlQ;
        blankD   = blankQ;
        blinkD   = blinkQ;
        pendingD = pendingQ;
        cntD     = (cntQ == CNT_LAST) ? '0 : cntQ + CNT_W'(1);
        phaseD   = (cntQ == CNT_LAST) ? ~phaseQ : phaseQ;

        if (writeEn) begin
            if (isDigit) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (4'(k) == iAddress) begin
                        shadowD[k] = iWrite_data[4:0];
                        if (!ctrlQ[1]) begin
                            activeD[k] = iWrite_data[4:0];
                        end
                    end
                end
                if (ctrlQ[1]) begin
                    pendingD = 1'b1;
                end
            end else begin
                case (iAddress)
                    ADDR_CTRL:   ctrlD  = iWrite_data[1:0];
                    ADDR_BLANK:  blankD = iWrite_data[NUM_DIGITS-1:0];
                    ADDR_BLINK:  blinkD = iWrite_data[NUM_DIGITS-1:0];
                    ADDR_COMMIT: begin
                        activeD  = shadowQ;
                        pendingD = 1'b0;
                    end
                    default: ;
                endcase
            end
        end

        readD = oRead_data;
        if (readEn) begin
            readD = '0;
            if (isDigit) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (4'(k) == iAddress) begin
                        readD = 32'(shadowQ[k]);
                    end
                end
            end else begin
                case (iAddress)
                    ADDR_CTRL:   readD = 32'(ctrlQ);
                    ADDR_BLANK:  readD = 32'(blankQ);
                    ADDR_BLINK:  readD = 32'(blinkQ);
                    ADDR_STATUS: readD = {30'b0, pendingQ, phaseQ};
                    default:     readD = '0;
                endcase
            end
        end

        // Segments are built from next-state values so a write shows on the very next edge.
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!ctrlD[0] || blankD[k] || (blinkD[k] && phaseD)) begin
                hexD[k*8 +: 8] = 8'hFF;
            end else begin
                hexD[k*8 +: 8] = {activeD[k][4], glyph(activeD[k][3:0])};
            end
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            shadowQ    <= '0;
            activeQ    <= '0;
            ctrlQ      <= 2'b01;
            blankQ     <= '0;
            blinkQ     <= '0;
            cntQ       <= '0;
            phaseQ     <= 1'b0;
            pendingQ   <= 1'b0;
            oRead_data <= '0;
            oHex       <= {NUM_DIGITS{8'h40}};
        end else begin
            shadowQ    <= shadowD;
            activeQ    <= activeD;
            ctrlQ      <= ctrlD;
            blankQ     <= blankD;
            blinkQ     <= blinkD;
            cntQ       <= cntD;
            phaseQ     <= phaseD;
            pendingQ   <= pendingD;
            oRead_data <= readD;
            oHex       <= hexD;
        end
    end
endmodule

// File: tb/tb_hex_display_bank.sv
// tb/tb_hex_display_bank.sv - directed and randomized checks of hex_display_bank against a reference model
module tb_hex_display_bank;
    localparam int ND   = 6;
    localparam int BDIV = 4;
    localparam logic [6:0] GLYPHS [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic          iClk;
    logic          iReset_n;
    logic          iChip_select_n;
    logic          iWrite_n;
    logic          iRead_n;
    logic [3:0]    iAddress;
    logic [31:0]   iWrite_data;
    logic [31:0]   oRead_data;
    logic [ND*8-1:0] oHex;

    hex_display_bank #(.NUM_DIGITS(ND), .BLINK_DIV(BDIV)) dut (
        .iClk           (iClk),
        .iReset_n       (iReset_n),
        .iChip_select_n (iChip_select_n),
        .iWrite_n       (iWrite_n),
        .iRead_n        (iRead_n),
        .iAddress       (iAddress),
        .iWrite_data    (iWrite_data),
        .oRead_data     (oRead_data),
        .oHex           (oHex)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    logic [4:0]    mShadow [ND];
    logic [4:0]    mActive [ND];
    logic [1:0]    mCtrl;
    logic [ND-1:0] mBlank;
    logic [ND-1:0] mBlink;
    logic          mPending;
    logic [31:0]   mRead;
    int            edges;
    int            vectors;
    int            miscompares;

    // Blink phase after n edges since reset release: toggles once every BDIV edges.
    function automatic logic mPhase(input int n);
        return ((n / BDIV) % 2) == 1;
    endfunction

    function automatic logic [ND*8-1:0] expHex();
        logic [ND*8-1:0] v;
        for (int k = 0; k < ND; k++) begin
            if (!mCtrl[0] || mBlank[k] || (mBlink[k] && mPhase(edges)))
                v[k*8 +: 8] = 8'hFF;
            else
                v[k*8 +: 8] = {mActive[k][4], GLYPHS[mActive[k][3:0]]};
        end
        return v;
    endfunction

    function automatic logic [31:0] modelRead(input logic [3:0] a);
        int idx;
        idx = int'(a);
        if (idx < ND) return 32'(mShadow[idx]);
        case (idx)
            8:       return 32'(mCtrl);
            9:       return 32'(mBlank);
            10:      return 32'(mBlink);
            12:      return {30'b0, mPending, mPhase(edges)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelWrite(input logic [3:0] a, input logic [31:0] d);
        int idx;
        idx = int'(a);
        if (idx < ND) begin
            mShadow[idx] = d[4:0];
            if (mCtrl[1]) mPending = 1'b1;
            else          mActive[idx] = d[4:0];
        end else if (idx == 8)  mCtrl  = d[1:0];
        else if (idx == 9)  mBlank = d[ND-1:0];
        else if (idx == 10) mBlink = d[ND-1:0];
        else if (idx == 11) begin
            for (int k = 0; k < ND; k++) mActive[k] = mShadow[k];
            mPending = 1'b0;
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < ND; k++) begin
            mShadow[k] = '0;
            mActive[k] = '0;
        end
        mCtrl    = 2'b01;
        mBlank   = '0;
        mBlink   = '0;
        mPending = 1'b0;
        mRead    = '0;
        edges    = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic csN, input logic wrN, input logic rdN,
                         input logic [3:0] a, input logic [31:0] d);
        iChip_select_n = csN;
        iWrite_n       = wrN;
        iRead_n        = rdN;
        iAddress       = a;
        iWrite_data    = d;
        @(posedge iClk);
        if (!csN && wrN && !rdN) mRead = modelRead(a);
        edges++;
        if (!csN && !wrN) modelWrite(a, d);
        #1;
        check("oHex", 64'(oHex), 64'(expHex()));
        check("oRead_data", 64'(oRead_data), 64'(mRead));
        iChip_select_n = 1'b1;
        iWrite_n       = 1'b1;
        iRead_n        = 1'b1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [3:0] a);
        cycle(1'b0, 1'b1, 1'b0, a, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] prevByte;
        int         toggles;
        vectors        = 0;
        miscompares    = 0;
        iReset_n       = 1'b0;
        iChip_select_n = 1'b1;
        iWrite_n       = 1'b1;
        iRead_n        = 1'b1;
        iAddress       = '0;
        iWrite_data    = '0;
        modelReset();
        #7;
        check("reset_hex", 64'(oHex), 64'({ND{8'h40}}));
        check("reset_read", 64'(oRead_data), 64'h0);
        @(negedge iClk);
        iReset_n = 1'b1;

        wr(4'd2, 32'h1A);
        check("digit2_dp", 64'(oHex[23:16]), 64'h88);
        check("digit_others", 64'({oHex[47:24], oHex[15:0]}), 64'({5{8'h40}}));

        wr(4'd8, 32'h3);
        wr(4'd0, 32'h5);
        check("shadow_hold", 64'(oHex[7:0]), 64'h40);
        rd(4'd12);
        check("status_pending", 64'(oRead_data[1]), 64'h1);
        wr(4'd11, 32'h0);
        check("commit_byte0", 64'(oHex[7:0]), 64'h12);
        rd(4'd12);
        check("status_cleared", 64'(oRead_data[1]), 64'h0);
        wr(4'd11, 32'h0);

        wr(4'd8, 32'h1);
        wr(4'd9, 32'h3);
        wr(4'd8, 32'h0);
        check("all_blank", 64'(oHex), 64'({ND{8'hFF}}));
        wr(4'd8, 32'h1);
        check("blank01", 64'(oHex[15:0]), 64'hFFFF);
        check("blank_byte2", 64'(oHex[23:16]), 64'h88);
        rd(4'd9);

        wr(4'd9, 32'h0);
        wr(4'd1, 32'h13);
        rd(4'd1);
        check("read_digit1", 64'(oRead_data), 64'h13);
        rd(4'd15);
        check("read_unmapped", 64'(oRead_data), 64'h0);
        wr(4'd7, 32'h1F);
        check("write_addr7", 64'(oHex[47:24]), 64'({3{8'h40}}));
        rd(4'd7);
        check("read_addr7", 64'(oRead_data), 64'h0);
        wr(4'd9, 32'hFFFF_FFFF);
        rd(4'd9);
        check("mask_width", 64'(oRead_data), 64'h3F);
        wr(4'd9, 32'h0);
        wr(4'd12, 32'hFFFF_FFFF);

        wr(4'd0, 32'h8);
        wr(4'd10, 32'h1);
        prevByte = oHex[7:0];
        toggles  = 0;
        for (int i = 0; i < 16; i++) begin
            rd(4'd12);
            check("blink_byte0", 64'(oHex[7:0]), mPhase(edges) ? 64'hFF : 64'h00);
            check("blink_status", 64'(oRead_data[0]), 64'(mPhase(edges - 1)));
            if (oHex[7:0] != prevByte) toggles++;
            prevByte = oHex[7:0];
        end
        check("blink_toggles", 64'(toggles), 64'd4);

        wr(4'd8, 32'h3);
        wr(4'd3, 32'h0F);
        #2;
        iReset_n = 1'b0;
        #1;
        modelReset();
        check("async_reset_hex", 64'(oHex), 64'({ND{8'h40}}));
        check("async_reset_read", 64'(oRead_data), 64'h0);
        @(negedge iClk);
        iReset_n = 1'b1;
        rd(4'd12);
        check("status_after_reset", 64'(oRead_data), 64'h0);
        wr(4'd11, 32'h0);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                  4'($urandom_range(0, 15)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
